// File: rtl/pixel_dispatch.sv
// Raster-order pixel dispatcher. Walks one frame per start and hands each
// pixel to exactly one of NUM_ENGINES engines over independent valid/ready
// slots. Free slots are filled in ascending index order, and every cycle the
// cursor advances by the number of pixels loaded.
//
// state      | meaning
// -----------+--------------------------------------------------------------
// S_IDLE     | waiting for start; the start cycle itself loads the first batch
// S_DISPATCH | loading free slots from the cursor until rem is exhausted
// S_DRAIN    | no loads; waiting for all slots empty and all engines idle
module pixel_dispatch #(
  parameter int COORD_WIDTH   = 32,
  parameter int SCREEN_WIDTH  = 640,
  parameter int SCREEN_HEIGHT = 480,
  parameter int NUM_ENGINES   = 3
) (
  input  logic                               clk,
  input  logic                               reset_n,
  input  logic                               start,
  input  logic                               scan_up,
  output logic [NUM_ENGINES-1:0]             eng_valid,
  input  logic [NUM_ENGINES-1:0]             eng_ready,
  output logic [NUM_ENGINES*COORD_WIDTH-1:0] eng_x,
  output logic [NUM_ENGINES*COORD_WIDTH-1:0] eng_y,
  input  logic [NUM_ENGINES-1:0]             eng_busy,
  output logic                               busy,
  output logic                               frame_done
);

  localparam int CW = COORD_WIDTH;
  localparam logic [CW-1:0] X_LAST    = CW'(SCREEN_WIDTH - 1);
  localparam logic [CW-1:0] Y_LAST    = CW'(SCREEN_HEIGHT - 1);
  localparam logic [CW-1:0] PIX_TOTAL = CW'(SCREEN_WIDTH * SCREEN_HEIGHT);
  localparam logic [CW-1:0] ONE       = CW'(1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_DISPATCH = 2'd1,
    S_DRAIN    = 2'd2
  } state_t;

  state_t                        state_q;
  logic [CW-1:0]                 cx_q, cy_q, rem_q;
  logic                          up_q;
  logic [NUM_ENGINES-1:0]        valid_q, valid_d;
  logic [NUM_ENGINES*CW-1:0]     x_q, x_d, y_q, y_d;
  logic                          busy_q, done_q;

  // start is ignored while the frame_done pulse is showing
  logic          start_ok;
  logic          load_en;
  logic [CW-1:0] cx_base, cy_base, rem_base;
  logic          dir_up;
  logic [CW-1:0] cx_c, cy_c, rem_c;

  assign start_ok = (state_q == S_IDLE) && start && !done_q;
  assign load_en  = start_ok || (state_q == S_DISPATCH);
  assign cx_base  = start_ok ? '0 : cx_q;
  assign cy_base  = start_ok ? (scan_up ? Y_LAST : '0) : cy_q;
  assign rem_base = start_ok ? PIX_TOTAL : rem_q;
  // scan_up=1 steps rows upward (cy+1) starting at the last row, wrapping to 0
  assign dir_up   = start_ok ? scan_up : up_q;

  // Fill free slots in index order, advancing a chained copy of the cursor per load
  always_comb begin
    logic free_slot;
    cx_c    = cx_base;
    cy_c    = cy_base;
    rem_c   = rem_base;
    valid_d = valid_q & ~eng_ready;
    x_d     = x_q;
    y_d     = y_q;
    free_slot = 1'b0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      free_slot = !valid_q[i] || eng_ready[i];
      if (load_en && free_slot && (rem_c != '0)) begin
        valid_d[i]          = 1'b1;
        x_d[i*CW +: CW]     = cx_c;
        y_d[i*CW +: CW]     = cy_c;
        rem_c               = rem_c - ONE;
        if (cx_c == X_LAST) begin
          cx_c = '0;
          if (dir_up) cy_c = (cy_c == Y_LAST) ? '0 : cy_c + ONE;
          else        cy_c = (cy_c == '0) ? Y_LAST : cy_c - ONE;
        end else begin
          cx_c = cx_c + ONE;
        end
      end
    end
  end

  // Frame FSM with slot registers, cursor and registered status outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      cx_q    <= '0;
      cy_q    <= '0;
      rem_q   <= '0;
      up_q    <= 1'b0;
      valid_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      valid_q <= valid_d;
      x_q     <= x_d;
      y_q     <= y_d;
      done_q  <= 1'b0;
      if (load_en) begin
        cx_q  <= cx_c;
        cy_q  <= cy_c;
        rem_q <= rem_c;
      end
      case (state_q)
        S_IDLE: begin
          if (start_ok) begin
            up_q    <= scan_up;
            busy_q  <= 1'b1;
            state_q <= S_DISPATCH;
          end
        end
        S_DISPATCH: begin
          if (rem_q == '0) state_q <= S_DRAIN;
        end
        S_DRAIN: begin
          if ((valid_q == '0) && (eng_busy == '0)) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign eng_valid  = valid_q;
  assign eng_x      = x_q;
  assign eng_y      = y_q;
  assign busy       = busy_q;
  assign frame_done = done_q;

endmodule

// File: tb/tb_pixel_dispatch.sv
// Bench for pixel_dispatch: fixed vector table on a 4x2 screen, hand
// sequences for busy-delayed completion, async abort and a 1x2 screen, and
// randomized ready traffic checked against an index-based raster model.
module tb_pixel_dispatch;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  // u_a: 3 engines, 4x2
  logic a_start, a_scan, a_busy, a_fd;
  logic [2:0] a_ready, a_ebusy, a_valid;
  logic [95:0] a_x, a_y;
  // u_b: 3 engines, 16x12
  logic b_start, b_scan, b_busy, b_fd;
  logic [2:0] b_ready, b_ebusy, b_valid;
  logic [95:0] b_x, b_y;
  // u_c: 4 engines, 1x2
  logic c_start, c_scan, c_busy, c_fd;
  logic [3:0] c_ready, c_ebusy, c_valid;
  logic [127:0] c_x, c_y;
  // u_d: 32 engines, 640x480
  logic d_start, d_scan, d_busy, d_fd;
  logic [31:0] d_ready, d_ebusy, d_valid;
  logic [1023:0] d_x, d_y;

  pixel_dispatch #(.COORD_WIDTH(32), .SCREEN_WIDTH(4), .SCREEN_HEIGHT(2), .NUM_ENGINES(3)) u_a (
    .clk(clk), .reset_n(rst_n), .start(a_start), .scan_up(a_scan), .eng_valid(a_valid),
    .eng_ready(a_ready), .eng_x(a_x), .eng_y(a_y), .eng_busy(a_ebusy), .busy(a_busy), .frame_done(a_fd));
  pixel_dispatch #(.COORD_WIDTH(32), .SCREEN_WIDTH(16), .SCREEN_HEIGHT(12), .NUM_ENGINES(3)) u_b (
    .clk(clk), .reset_n(rst_n), .start(b_start), .scan_up(b_scan), .eng_valid(b_valid),
    .eng_ready(b_ready), .eng_x(b_x), .eng_y(b_y), .eng_busy(b_ebusy), .busy(b_busy), .frame_done(b_fd));
  pixel_dispatch #(.COORD_WIDTH(32), .SCREEN_WIDTH(1), .SCREEN_HEIGHT(2), .NUM_ENGINES(4)) u_c (
    .clk(clk), .reset_n(rst_n), .start(c_start), .scan_up(c_scan), .eng_valid(c_valid),
    .eng_ready(c_ready), .eng_x(c_x), .eng_y(c_y), .eng_busy(c_ebusy), .busy(c_busy), .frame_done(c_fd));
  pixel_dispatch #(.COORD_WIDTH(32), .SCREEN_WIDTH(640), .SCREEN_HEIGHT(480), .NUM_ENGINES(32)) u_d (
    .clk(clk), .reset_n(rst_n), .start(d_start), .scan_up(d_scan), .eng_valid(d_valid),
    .eng_ready(d_ready), .eng_x(d_x), .eng_y(d_y), .eng_busy(d_ebusy), .busy(d_busy), .frame_done(d_fd));

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: actual %0d required %0d", nm, act, exp);
    end
  endtask

  // Pixel k of a frame: x = k mod W, row r = k div W; scan_up starts at row
  // H-1 and counts up with wrap, otherwise starts at row 0 and counts down.
  function automatic void pix(input int k, input int w, input int h, input bit up,
                              output int x, output int y);
    int r;
    x = k % w;
    r = k / w;
    y = up ? (h - 1 + r) % h : (h - r) % h;
  endfunction

  typedef struct {
    logic        st;
    logic [2:0]  v;
    logic [11:0] xs;
    logic [11:0] ys;
    logic        bsy;
    logic        fd;
  } vec_t;

  vec_t tbl [8];

  task automatic run_a_frame(input int hold, output int delta);
    int cyc, last, hcnt;
    bit seen_fd;
    cyc = 0; last = -1; hcnt = 0; seen_fd = 0;
    @(negedge clk); a_start = 1'b1; a_scan = 1'b0; a_ready = '1; a_ebusy = '0;
    @(negedge clk); a_start = 1'b0; cyc = 1;
    while (!seen_fd && cyc < 50) begin
      if (a_valid != 3'b000) last = cyc;
      if (a_fd) seen_fd = 1'b1;
      if (last >= 0 && a_valid == 3'b000 && hcnt < hold && !seen_fd) begin
        a_ebusy = '1; hcnt++;
      end else begin
        a_ebusy = '0;
      end
      if (!seen_fd) begin @(negedge clk); cyc++; end
    end
    delta = seen_fd ? cyc - last : -1;
  endtask

  task automatic run_b(input bit up);
    localparam int TOT = 192;
    localparam int BP = 20;
    int next_k, acc, dup, bad, cyc, ex, ey, l0, l2, held1;
    bit prev_free [3];
    logic [31:0] px [3];
    logic [31:0] py [3];
    bit seen [TOT];
    bit fd;
    logic [2:0] r;
    logic [31:0] cx, cy;
    next_k = 0; acc = 0; dup = 0; bad = 0; cyc = 0; l0 = 0; l2 = 0; held1 = 0; fd = 0;
    foreach (seen[i]) seen[i] = 1'b0;
    for (int i = 0; i < 3; i++) begin prev_free[i] = 1'b1; px[i] = '0; py[i] = '0; end
    @(negedge clk); b_start = 1'b1; b_scan = up; b_ready = '0; b_ebusy = '0;
    @(negedge clk); b_start = 1'b0; b_scan = 1'($urandom_range(0, 1));
    while (!fd && cyc < 3000) begin
      for (int i = 0; i < 3; i++) begin
        cx = b_x[i*32 +: 32]; cy = b_y[i*32 +: 32];
        if (prev_free[i]) begin
          if (next_k < TOT) begin
            pix(next_k, 16, 12, up, ex, ey);
            if (!b_valid[i] || cx != 32'(ex) || cy != 32'(ey)) bad++;
            else if (cyc > BP && cyc <= BP + 10) begin
              if (i == 0) l0++;
              if (i == 2) l2++;
            end
            next_k++;
          end else if (b_valid[i]) bad++;
        end else if (!b_valid[i] || cx != px[i] || cy != py[i]) bad++;
        else if (i == 1 && cyc > BP && cyc <= BP + 10) held1++;
      end
      fd = b_fd;
      for (int i = 0; i < 3; i++) r[i] = ($urandom_range(0, 3) != 0);
      if (cyc >= BP && cyc < BP + 10) r = 3'b101;
      b_ready = r;
      for (int i = 0; i < 3; i++) begin
        cx = b_x[i*32 +: 32]; cy = b_y[i*32 +: 32];
        if (b_valid[i] && r[i]) begin
          acc++;
          if (cx < 16 && cy < 12) begin
            if (seen[cy*16 + cx]) dup++;
            seen[cy*16 + cx] = 1'b1;
          end else bad++;
        end
        prev_free[i] = !b_valid[i] || r[i];
        px[i] = cx; py[i] = cy;
      end
      if (!fd) begin @(negedge clk); cyc++; end
    end
    b_ready = '0;
    chk("t4_stream_errors", bad, 0);
    chk("t4_pixels_issued", next_k, TOT);
    chk("t4_pixels_accepted", acc, TOT);
    chk("t4_duplicates", dup, 0);
    chk("t4_frame_done_seen", fd, 1);
    chk("t4_busy_after_done", b_busy, 0);
    chk("t3_slot0_loads", l0, 10);
    chk("t3_slot2_loads", l2, 10);
    chk("t3_slot1_held", held1, 10);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int d0, d5, cyc, bad, ex, ey;
    bit got;
    tbl[0] = '{1'b1, 3'b000, 12'h000, 12'h000, 1'b0, 1'b0};
    tbl[1] = '{1'b0, 3'b111, 12'h210, 12'h000, 1'b1, 1'b0};
    tbl[2] = '{1'b0, 3'b111, 12'h103, 12'h110, 1'b1, 1'b0};
    tbl[3] = '{1'b0, 3'b011, 12'h032, 12'h011, 1'b1, 1'b0};
    tbl[4] = '{1'b0, 3'b000, 12'h000, 12'h000, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 3'b000, 12'h000, 12'h000, 1'b0, 1'b1};
    tbl[6] = '{1'b0, 3'b000, 12'h000, 12'h000, 1'b0, 1'b0};
    tbl[7] = '{1'b0, 3'b000, 12'h000, 12'h000, 1'b0, 1'b0};

    rst_n = 1'b0;
    a_start = 0; a_scan = 0; a_ready = '1; a_ebusy = '0;
    b_start = 0; b_scan = 0; b_ready = '0; b_ebusy = '0;
    c_start = 0; c_scan = 0; c_ready = '0; c_ebusy = '0;
    d_start = 0; d_scan = 0; d_ready = '0; d_ebusy = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_x_zero", |a_x, 0);
    chk("reset_y_zero", |a_y, 0);

    // T1: table of expected slot contents on the 4x2 screen
    for (int r = 0; r < 8; r++) begin
      @(negedge clk);
      chk($sformatf("t1_valid_row%0d", r), a_valid, tbl[r].v);
      for (int i = 0; i < 3; i++)
        if (tbl[r].v[i]) begin
          chk($sformatf("t1_x_row%0d_slot%0d", r, i), a_x[i*32 +: 32], tbl[r].xs[i*4 +: 4]);
          chk($sformatf("t1_y_row%0d_slot%0d", r, i), a_y[i*32 +: 32], tbl[r].ys[i*4 +: 4]);
        end
      chk($sformatf("t1_busy_row%0d", r), a_busy, tbl[r].bsy);
      chk($sformatf("t1_done_row%0d", r), a_fd, tbl[r].fd);
      a_start = tbl[r].st;
    end

    // T4: engine busy after the last accept delays frame_done cycle for cycle
    run_a_frame(0, d0);
    run_a_frame(5, d5);
    chk("t4_done_seen_base", d0 > 0, 1);
    chk("t4_done_delay", d5 - d0, 5);

    // T5: asynchronous abort mid-frame, then clean restart
    @(negedge clk); a_start = 1'b1; a_scan = 1'b0; a_ready = '0;
    @(negedge clk); a_start = 1'b0;
    @(negedge clk);
    chk("t5_valid_before_reset", a_valid, 3'b111);
    #2 rst_n = 1'b0;
    #1;
    chk("t5_valid_async", a_valid, 0);
    chk("t5_x_async", |a_x, 0);
    chk("t5_y_async", |a_y, 0);
    chk("t5_busy_async", a_busy, 0);
    got = 1'b0;
    repeat (3) begin @(negedge clk); if (a_fd) got = 1'b1; end
    rst_n = 1'b1; a_ready = '1;
    repeat (3) begin @(negedge clk); if (a_fd) got = 1'b1; end
    chk("t5_no_frame_done", got, 0);
    a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    chk("t5_restart_valid", a_valid, 3'b111);
    chk("t5_restart_x0", a_x[31:0], 0);
    chk("t5_restart_y0", a_y[31:0], 0);
    chk("t5_restart_x1", a_x[63:32], 1);
    got = 1'b0; cyc = 0;
    while (!got && cyc < 30) begin @(negedge clk); got = a_fd; cyc++; end
    chk("t5_restart_completes", got, 1);

    // T6: 1x2 screen on 4 engines, start during DISPATCH/DRAIN ignored
    @(negedge clk); c_start = 1'b1; c_scan = 1'b0; c_ready = '1; c_ebusy = '0;
    @(negedge clk);
    chk("t6_valid", c_valid, 4'b0011);
    chk("t6_s0_x", c_x[31:0], 0);
    chk("t6_s0_y", c_y[31:0], 0);
    chk("t6_s1_x", c_x[63:32], 0);
    chk("t6_s1_y", c_y[63:32], 1);
    c_start = 1'b1; c_ebusy = '1;
    @(negedge clk);
    chk("t6_drain_valid", c_valid, 0);
    chk("t6_drain_busy", c_busy, 1);
    @(negedge clk);
    chk("t6_drain_no_restart", c_valid, 0);
    chk("t6_drain_busy_held", c_busy, 1);
    c_start = 1'b0; c_ebusy = '0;
    @(negedge clk);
    chk("t6_done", c_fd, 1);
    chk("t6_done_busy", c_busy, 0);
    @(negedge clk);
    chk("t6_idle_valid", c_valid, 0);
    chk("t6_idle_busy", c_busy, 0);
    chk("t6_done_pulse", c_fd, 0);

    // T3/T4: randomized ready against the raster model, both directions
    run_b(1'b0);
    run_b(1'b1);

    // T2: full 640x480 frame, scan_up=1, 32 engines always ready
    @(negedge clk); d_start = 1'b1; d_scan = 1'b1; d_ready = '1;
    @(negedge clk); d_start = 1'b0;
    bad = 0;
    for (cyc = 1; cyc <= 9600; cyc++) begin
      for (int i = 0; i < 32; i++) begin
        pix((cyc - 1) * 32 + i, 640, 480, 1'b1, ex, ey);
        if (!d_valid[i] || d_x[i*32 +: 32] != 32'(ex) || d_y[i*32 +: 32] != 32'(ey)) bad++;
      end
      if (cyc == 1) begin
        chk("t2_first_x", d_x[31:0], 0);
        chk("t2_first_y", d_y[31:0], 479);
      end
      if (cyc == 21) begin
        chk("t2_pix640_x", d_x[31:0], 0);
        chk("t2_pix640_y", d_y[31:0], 0);
        chk("t2_pix641_x", d_x[63:32], 1);
        chk("t2_pix641_y", d_y[63:32], 0);
      end
      if (cyc == 9600) begin
        chk("t2_last_x", d_x[1023:992], 639);
        chk("t2_last_y", d_y[1023:992], 478);
      end
      @(negedge clk);
    end
    chk("t2_stream_errors", bad, 0);
    got = 1'b0; cyc = 0;
    while (!got && cyc < 20) begin
      if (d_fd) got = 1'b1;
      else begin @(negedge clk); cyc++; end
    end
    chk("t2_frame_done", got, 1);
    chk("t2_busy_after_done", d_busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
